// File: rtl/dbus_fabric.sv
// Data-bus interconnect: decodes the CPU data port onto NSLV slaves with
// per-slave wait states, a ready timeout and sticky error capture.
module dbus_fabric #(
  parameter int                NSLV     = 4,
  parameter int                AW       = 24,
  parameter int                DW       = 32,
  parameter int                SEL_LSB  = 21,
  parameter int                SEL_BITS = 3,
  parameter logic [NSLV*4-1:0] WAIT_CYC = {NSLV{4'd0}},
  parameter int                TIMEOUT  = 16,
  parameter logic [DW-1:0]     ERR_DATA = DW'(32'hDEAD_BEEF),
  localparam int               BW       = DW / 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [AW-1:0]        i_cpu_addr,
  input  logic                 i_cpu_rd,
  input  logic [BW-1:0]        i_cpu_wr,
  input  logic [DW-1:0]        i_cpu_dout,
  output logic [DW-1:0]        o_cpu_din,
  output logic                 o_cpu_stall,
  output logic                 o_cpu_ack,
  output logic                 o_cpu_err,
  output logic [AW-1:0]        o_s_addr,
  output logic [DW-1:0]        o_s_dout,
  output logic [NSLV-1:0]      o_s_rd,
  output logic [NSLV*BW-1:0]   o_s_wr,
  input  logic [NSLV*DW-1:0]   i_s_din,
  input  logic [NSLV-1:0]      i_s_ready,
  output logic                 o_err_sticky,
  output logic [AW-1:0]        o_err_addr,
  input  logic                 i_err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ACK} state_t;

  state_t              state_q;
  logic [7:0]          cnt_q;
  logic [SEL_BITS-1:0] idx_q;
  logic                wr_q;
  logic [BW-1:0]       be_q;
  logic                err_q;

  logic                req;
  logic [SEL_BITS-1:0] sel;
  logic                dec_err;
  logic [3:0]          wait_sel;
  logic                rdy_sel;
  logic [DW-1:0]       din_sel;
  logic                err_set;
  logic [AW-1:0]       err_addr_d;

  assign req     = i_cpu_rd | (|i_cpu_wr);
  assign sel     = i_cpu_addr[SEL_LSB +: SEL_BITS];
  assign dec_err = int'(sel) >= NSLV;

  always_comb begin
    wait_sel = '0;
    rdy_sel  = 1'b0;
    din_sel  = '0;
    o_s_rd   = '0;
    o_s_wr   = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel == SEL_BITS'(i)) wait_sel = WAIT_CYC[i*4 +: 4];
      if (idx_q == SEL_BITS'(i)) begin
        rdy_sel = i_s_ready[i];
        din_sel = i_s_din[i*DW +: DW];
        // Only the latched slave is strobed, and only while the transfer is open.
        if (state_q == S_WAIT || state_q == S_RESP) begin
          o_s_rd[i]           = ~wr_q;
          o_s_wr[i*BW +: BW]  = be_q;
        end
      end
    end
  end

  assign err_set    = (state_q == S_IDLE && req && dec_err) ||
                      (state_q == S_RESP && !rdy_sel && cnt_q == 8'd1);
  assign err_addr_d = (state_q == S_IDLE) ? i_cpu_addr : o_s_addr;

  assign o_cpu_stall = (state_q == S_IDLE && req) || state_q == S_WAIT || state_q == S_RESP;
  assign o_cpu_ack   = (state_q == S_ACK);
  assign o_cpu_err   = (state_q == S_ACK) && err_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      wr_q         <= 1'b0;
      be_q         <= '0;
      err_q        <= 1'b0;
      o_cpu_din    <= '0;
      o_s_addr     <= '0;
      o_s_dout     <= '0;
      o_err_sticky <= 1'b0;
      o_err_addr   <= '0;
    end else begin
      // A new error outranks a simultaneous clear.
      if (err_set) begin
        o_err_sticky <= 1'b1;
        if (!o_err_sticky || i_err_clr) o_err_addr <= err_addr_d;
      end else if (i_err_clr) begin
        o_err_sticky <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (req) begin
            o_s_addr <= i_cpu_addr;
            o_s_dout <= i_cpu_dout;
            be_q     <= i_cpu_wr;
            wr_q     <= |i_cpu_wr;
            idx_q    <= sel;
            cnt_q    <= 8'(wait_sel);
            if (dec_err) begin
              err_q     <= 1'b1;
              o_cpu_din <= ERR_DATA;
              state_q   <= S_ACK;
            end else begin
              err_q   <= 1'b0;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 8'd0) begin
            cnt_q   <= 8'(TIMEOUT);
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_RESP: begin
          if (rdy_sel) begin
            if (!wr_q) o_cpu_din <= din_sel;
            err_q   <= 1'b0;
            state_q <= S_ACK;
          end else if (cnt_q == 8'd1) begin
            err_q     <= 1'b1;
            o_cpu_din <= ERR_DATA;
            state_q   <= S_ACK;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_fabric.sv
// Directed bench for dbus_fabric: decode, wait states, timeout, errors, reset.
module tb_dbus_fabric;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [23:0]  cpu_addr = '0;
  logic         cpu_rd = 1'b0;
  logic [3:0]   cpu_wr = '0;
  logic [31:0]  cpu_dout = '0;
  logic [31:0]  cpu_din;
  logic         cpu_stall, cpu_ack, cpu_err;
  logic [23:0]  s_addr;
  logic [31:0]  s_dout;
  logic [3:0]   s_rd;
  logic [15:0]  s_wr;
  logic [127:0] s_din = '0;
  logic [3:0]   s_ready = '0;
  logic         err_sticky;
  logic [23:0]  err_addr;
  logic         err_clr = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  int          lat, stb, stl;
  logic        er;
  logic [31:0] din;
  logic [3:0]  rd_or;
  logic [15:0] wr_or;

  dbus_fabric #(
    .NSLV(4), .AW(24), .DW(32), .SEL_LSB(21), .SEL_BITS(3),
    .WAIT_CYC(16'h0300), .TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_addr(cpu_addr), .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr), .i_cpu_dout(cpu_dout),
    .o_cpu_din(cpu_din), .o_cpu_stall(cpu_stall), .o_cpu_ack(cpu_ack), .o_cpu_err(cpu_err),
    .o_s_addr(s_addr), .o_s_dout(s_dout), .o_s_rd(s_rd), .o_s_wr(s_wr),
    .i_s_din(s_din), .i_s_ready(s_ready),
    .o_err_sticky(err_sticky), .o_err_addr(err_addr), .i_err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Launches one transfer and watches it until ack or the cycle budget runs out.
  task automatic xfer(input logic [23:0] a, input logic rd, input logic [3:0] wr,
                      input logic [31:0] d, input logic clr, input int budget,
                      output int o_lat, output logic o_err, output logic [31:0] o_din,
                      output int o_stb, output logic [3:0] o_rd_or,
                      output logic [15:0] o_wr_or, output int o_stall);
    o_lat = -1; o_err = 1'bx; o_din = 'x; o_stb = 0; o_rd_or = '0; o_wr_or = '0; o_stall = 0;
    @(posedge clk); #1;
    cpu_addr = a; cpu_rd = rd; cpu_wr = wr; cpu_dout = d; err_clr = clr;
    for (int c = 0; c <= budget; c++) begin
      @(negedge clk);
      if (s_rd != 0 || s_wr != 0) o_stb++;
      o_rd_or |= s_rd;
      o_wr_or |= s_wr;
      if (cpu_stall) o_stall++;
      if (cpu_ack) begin
        o_lat = c; o_err = cpu_err; o_din = cpu_din;
        break;
      end
      @(posedge clk); #1;
      err_clr = 1'b0;
    end
    cpu_rd = 1'b0; cpu_wr = '0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if ({cpu_ack, cpu_err, err_sticky, cpu_stall} !== 4'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000", {cpu_ack, cpu_err, err_sticky, cpu_stall}); end
    n_chk++; if ({s_rd, s_wr} !== 20'h0) begin n_fail++;
      $display("FAIL reset_strobes: got %h want 0", {s_rd, s_wr}); end
    n_chk++; if ({cpu_din, err_addr, s_addr, s_dout} !== 104'h0) begin n_fail++;
      $display("FAIL reset_data: got %h want 0", {cpu_din, err_addr, s_addr, s_dout}); end
  endtask

  task automatic test_read();
    s_din[31:0] = 32'h1234_5678; s_ready = 4'b0001;
    xfer(24'h000010, 1'b1, 4'b0000, 32'h0, 1'b0, 40, lat, er, din, stb, rd_or, wr_or, stl);
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d want 3", lat); end
    n_chk++; if (din !== 32'h1234_5678) begin n_fail++; $display("FAIL read_data: got %h want 12345678", din); end
    n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b want 0", er); end
    n_chk++; if (stb !== 2 || rd_or !== 4'b0001 || wr_or !== 16'h0) begin n_fail++;
      $display("FAIL read_strobes: got cyc=%0d rd=%b wr=%h want 2/0001/0000", stb, rd_or, wr_or); end
    n_chk++; if (stl !== 3) begin n_fail++; $display("FAIL read_stall: got %0d want 3", stl); end
    n_chk++; if (s_addr !== 24'h000010) begin n_fail++; $display("FAIL read_addr: got %h want 000010", s_addr); end
  endtask

  task automatic test_write_wait();
    s_ready = 4'b0100;
    xfer(24'h400008, 1'b0, 4'b0100, 32'hA5A5_C3C3, 1'b0, 40, lat, er, din, stb, rd_or, wr_or, stl);
    n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL wr_latency: got %0d want 6", lat); end
    n_chk++; if (stb !== 5 || wr_or !== 16'h0400 || rd_or !== 4'b0) begin n_fail++;
      $display("FAIL wr_strobes: got cyc=%0d wr=%h rd=%b want 5/0400/0000", stb, wr_or, rd_or); end
    n_chk++; if (stl !== 6) begin n_fail++; $display("FAIL wr_stall: got %0d want 6", stl); end
    n_chk++; if (din !== 32'h1234_5678 || er !== 1'b0) begin n_fail++;
      $display("FAIL wr_din_hold: got %h err=%b want 12345678 err=0", din, er); end
    n_chk++; if (s_dout !== 32'hA5A5_C3C3) begin n_fail++; $display("FAIL wr_sdout: got %h want a5a5c3c3", s_dout); end
  endtask

  task automatic test_decode_err();
    xfer(24'hA00000, 1'b1, 4'b0000, 32'h0, 1'b0, 40, lat, er, din, stb, rd_or, wr_or, stl);
    n_chk++; if (lat !== 1 || er !== 1'b1) begin n_fail++;
      $display("FAIL dec_ack: got lat=%0d err=%b want 1/1", lat, er); end
    n_chk++; if (din !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dec_data: got %h want deadbeef", din); end
    n_chk++; if (stb !== 0) begin n_fail++; $display("FAIL dec_strobes: got %0d want 0", stb); end
    n_chk++; if (err_sticky !== 1'b1 || err_addr !== 24'hA00000) begin n_fail++;
      $display("FAIL dec_sticky: got %b/%h want 1/a00000", err_sticky, err_addr); end
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    n_chk++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL dec_clr: got %b want 0", err_sticky); end
  endtask

  task automatic test_timeout();
    s_ready = 4'b0000;
    xfer(24'h200040, 1'b1, 4'b0000, 32'h0, 1'b0, 60, lat, er, din, stb, rd_or, wr_or, stl);
    n_chk++; if (lat !== 18 || er !== 1'b1) begin n_fail++;
      $display("FAIL to_ack: got lat=%0d err=%b want 18/1", lat, er); end
    n_chk++; if (stb !== 17 || rd_or !== 4'b0010 || din !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL to_strobes: got cyc=%0d rd=%b din=%h want 17/0010/deadbeef", stb, rd_or, din); end
    n_chk++; if (err_sticky !== 1'b1 || err_addr !== 24'h200040) begin n_fail++;
      $display("FAIL to_sticky: got %b/%h want 1/200040", err_sticky, err_addr); end
    xfer(24'hE00000, 1'b1, 4'b0000, 32'h0, 1'b0, 40, lat, er, din, stb, rd_or, wr_or, stl);
    n_chk++; if (lat !== 1 || er !== 1'b1 || err_addr !== 24'h200040) begin n_fail++;
      $display("FAIL to_second: got lat=%0d err=%b addr=%h want 1/1/200040", lat, er, err_addr); end
    xfer(24'hC00004, 1'b1, 4'b0000, 32'h0, 1'b1, 40, lat, er, din, stb, rd_or, wr_or, stl);
    n_chk++; if (err_sticky !== 1'b1 || err_addr !== 24'hC00004) begin n_fail++;
      $display("FAIL to_clr_vs_err: got %b/%h want 1/c00004", err_sticky, err_addr); end
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    n_chk++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL to_clr: got %b want 0", err_sticky); end
  endtask

  task automatic test_rd_wr_both();
    s_ready = 4'b0001;
    xfer(24'h000020, 1'b1, 4'b1111, 32'h0BAD_F00D, 1'b0, 40, lat, er, din, stb, rd_or, wr_or, stl);
    n_chk++; if (lat !== 3 || er !== 1'b0) begin n_fail++;
      $display("FAIL both_ack: got lat=%0d err=%b want 3/0", lat, er); end
    n_chk++; if (rd_or !== 4'b0 || wr_or !== 16'h000F) begin n_fail++;
      $display("FAIL both_strobes: got rd=%b wr=%h want 0000/000f", rd_or, wr_or); end
  endtask

  task automatic test_reset_mid();
    bit saw_ack;
    s_ready = 4'b0000;
    s_din[127:96] = 32'hCAFE_0003;
    @(posedge clk); #1;
    cpu_addr = 24'h600000; cpu_rd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (s_rd !== 4'b1000) begin n_fail++; $display("FAIL mid_pre: got %b want 1000", s_rd); end
    rst = 1'b1; cpu_rd = 1'b0;
    #1;
    n_chk++; if (s_rd !== 4'b0 || cpu_ack !== 1'b0) begin n_fail++;
      $display("FAIL mid_drop: got rd=%b ack=%b want 0000/0", s_rd, cpu_ack); end
    saw_ack = 1'b0;
    repeat (2) begin @(negedge clk); if (cpu_ack) saw_ack = 1'b1; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (cpu_ack) saw_ack = 1'b1; end
    n_chk++; if (saw_ack !== 1'b0 || s_addr !== 24'h0) begin n_fail++;
      $display("FAIL mid_noack: got ack=%b addr=%h want 0/000000", saw_ack, s_addr); end
    s_ready = 4'b1000;
    xfer(24'h600000, 1'b1, 4'b0000, 32'h0, 1'b0, 40, lat, er, din, stb, rd_or, wr_or, stl);
    n_chk++; if (lat !== 3 || er !== 1'b0 || din !== 32'hCAFE_0003) begin n_fail++;
      $display("FAIL mid_after: got lat=%0d err=%b din=%h want 3/0/cafe0003", lat, er, din); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_read();
    test_write_wait();
    test_decode_err();
    test_timeout();
    test_rd_wr_both();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_fabric.md
Name: dbus_fabric

Overview:
- Parametrised data-bus interconnect between the CPU data port and NSLV memory-mapped slaves (RAM, GPIO, timers, UART, ...).
- Replaces the fixed single-bit GPIO/RAM select with:
  - address-field slave decode;
  - per-slave programmable wait states;
  - slave ready handshake with timeout;
  - decode/timeout error reporting.
- Sits between the CPU data port and all data-side slaves at system level.

Parameters:
- NSLV, 4, number of slave ports (1..16).
- AW, 24, address width.
- DW, 32, data width (multiple of 8); BW = DW/8 byte lanes.
- SEL_LSB, 21, lowest address bit of the slave-select field.
- SEL_BITS, 3, width of the slave-select field.
- WAIT_CYC, {NSLV{4'd0}}, packed 4 bits per slave: wait states before ready is sampled.
- TIMEOUT, 16, cycles allowed for ready after the wait states expire (1..255).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error (low DW bits).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous reset, active-high
- i_cpu_addr  in  AW  CPU byte address
- i_cpu_rd  in  1  read request
- i_cpu_wr  in  BW  byte write enables
- i_cpu_dout  in  DW  CPU write data
- o_cpu_din  out  DW  read data to CPU
- o_cpu_stall  out  1  CPU must hold request stable
- o_cpu_ack  out  1  one-cycle transfer-complete pulse
- o_cpu_err  out  1  one-cycle error pulse, coincident with ack
- o_s_addr  out  AW  latched address to all slaves
- o_s_dout  out  DW  latched write data to all slaves
- o_s_rd  out  NSLV  per-slave read strobe
- o_s_wr  out  NSLV*BW  per-slave byte write enables
- i_s_din  in  NSLV*DW  packed slave read data
- i_s_ready  in  NSLV  per-slave ready
- o_err_sticky  out  1  sticky error flag
- o_err_addr  out  AW  address of first unacknowledged error
- i_err_clr  in  1  clears o_err_sticky

Behaviour:
- Request definition
  - req = i_cpu_rd | (|i_cpu_wr).
  - If any write enable is set, the transfer is a write and i_cpu_rd is ignored.
- Decode
  - idx = i_cpu_addr[SEL_LSB +: SEL_BITS].
  - idx >= NSLV is a decode error.
- State machine: IDLE, WAIT, RESP, ACK.
- IDLE
  - On req:
    - latch addr, wdata, write enables, rd/wr type and idx;
    - load wait counter with WAIT_CYC[idx];
    - go to WAIT.
  - On decode error: go to ACK with err set; no slave strobe asserted.
- WAIT
  - Strobes for the latched idx asserted: o_s_rd[idx] or o_s_wr[idx*BW +: BW].
  - Counter decrements each cycle; at 0, load the timeout counter with TIMEOUT and go to RESP.
- RESP
  - Strobes remain asserted.
  - If i_s_ready[idx]=1:
    - register the read data (i_s_din slice) into o_cpu_din; on writes o_cpu_din holds its prior value;
    - go to ACK.
  - Else decrement the timeout counter; on reaching 0 go to ACK with err set.
- ACK
  - Strobes deasserted; o_cpu_ack=1.
  - If err: o_cpu_err=1, o_cpu_din=ERR_DATA, o_err_sticky set, o_err_addr loaded only if o_err_sticky was 0.
  - Any CPU request present this cycle is the completed one and is not relaunched.
  - Go to IDLE.
- Latency
  - WAIT_CYC=0 and ready already high: request in cycle N, o_cpu_ack in cycle N+3.
  - Each wait state adds one cycle.
- Stall
  - o_cpu_stall = (IDLE & req) | WAIT | RESP; combinational.
  - Low in ACK.
- Error clear
  - i_err_clr clears o_err_sticky.
  - If i_err_clr coincides with a new error, the error wins: sticky stays set and the address reloads.
- Strobe ownership: only the latched slave ever sees a strobe; all other slaves' strobes stay 0.
- Reset values (asynchronous on i_rst)
  - state=IDLE.
  - All strobes, o_cpu_ack, o_cpu_err, o_err_sticky = 0.
  - o_cpu_din, o_err_addr, o_s_addr, o_s_dout = 0.
  - Reset mid-transfer drops the strobes immediately and no ack is issued.

Test Plan:
- Read, WAIT_CYC[0]=0, addr 0x000010, slave0 ready=1, data 0x12345678 -> o_s_rd=4'b0001 for 2 cycles; ack in cycle N+3; o_cpu_din=0x12345678; err=0.
- Byte write i_cpu_wr=4'b0100 to slave 2 (addr 0x400008), WAIT_CYC[2]=3 -> o_s_wr[11:8]=4'b0100 for 5 cycles; stall high until ack at N+6; other slave strobes 0.
- Read to idx=5 (addr 0xA00000) with NSLV=4 -> no strobes; ack+err at N+1; o_cpu_din=0xDEADBEEF; o_err_addr=0xA00000; sticky=1.
- Slave 1 ready held 0, TIMEOUT=16 -> ack+err after WAIT + 16 cycles; second error before i_err_clr keeps o_err_addr at the first address; i_err_clr clears sticky.
- i_cpu_rd=1 with i_cpu_wr=4'b1111 -> write performed; o_s_rd stays 0.
- Assert i_rst during RESP -> strobes 0 in the same cycle; no ack; next request completes normally.
